// File: rtl/hoplite_pe_ni_pkg.sv
// Shared packet layout for the Hoplite switch and its PE network interface.
// Field positions are derived from the torus address widths.
package hoplite_pe_ni_pkg;

  function automatic int pkt_x_lsb();
    return 0;
  endfunction

  function automatic int pkt_y_lsb(input int x_aw);
    return x_aw;
  endfunction

  function automatic int pkt_pay_lsb(input int x_aw, input int y_aw);
    return x_aw + y_aw;
  endfunction

  // Which producer writes the ejection FIFO in a given cycle.
  typedef enum logic [1:0] {
    EJ_NONE = 2'd0,
    EJ_NET  = 2'd1,
    EJ_LOOP = 2'd2
  } ej_src_e;

endpackage

// File: rtl/hoplite_pe_ni_pkt_fifo.sv
// Synchronous packet FIFO with a registered read pointer; storage is not reset.
// Push and pop may both occur at full; the caller decides when a push is legal.
module pkt_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_din,
  input  logic         i_pop,
  output logic [W-1:0] o_dout,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
  end

  assign o_dout  = r_mem[r_rd_ptr[AW-1:0]];
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

endmodule

// File: rtl/hoplite_pe_ni.sv
// PE network interface for a Hoplite torus switch: injection FIFO toward the
// switch, ejection FIFO toward the client, local loopback and drop accounting.
module hoplite_pe_ni
  import hoplite_pe_ni_pkg::*;
#(
  parameter int P_W   = 32,
  parameter int X_AW  = 2,
  parameter int Y_AW  = 2,
  parameter int X_POS = 0,
  parameter int Y_POS = 0,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [X_AW-1:0]        tx_dstx,
  input  logic [Y_AW-1:0]        tx_dsty,
  input  logic [P_W-X_AW-Y_AW-1:0] tx_data,
  input  logic                   tx_vld,
  output logic                   tx_rdy,
  output logic [P_W-1:0]         pein_pkt,
  output logic                   pein_vld,
  input  logic                   peout_rdy,
  input  logic [P_W-1:0]         yout_pkt,
  input  logic                   peout_vld,
  output logic [P_W-1:0]         rx_pkt,
  output logic                   rx_vld,
  input  logic                   rx_rdy,
  output logic [7:0]             drop_cnt,
  output logic                   ovf
);
  localparam int X_LSB = pkt_x_lsb();
  localparam int Y_LSB = pkt_y_lsb(X_AW);
  localparam int D_LSB = pkt_pay_lsb(X_AW, Y_AW);
  localparam int D_W   = P_W - X_AW - Y_AW;

  logic [P_W-1:0] w_tx_pkt;
  logic [P_W-1:0] w_ej_din;
  logic           w_local;
  logic           w_inj_full, w_inj_empty, w_inj_push, w_inj_pop;
  logic           w_ej_full, w_ej_empty, w_ej_push, w_ej_pop, w_ej_room;
  logic           w_drop;
  ej_src_e        w_ej_src;
  logic [7:0]     r_drop_cnt;
  logic           r_ovf;

  always_comb begin
    w_tx_pkt = '0;
    w_tx_pkt[X_LSB +: X_AW] = tx_dstx;
    w_tx_pkt[Y_LSB +: Y_AW] = tx_dsty;
    w_tx_pkt[D_LSB +: D_W]  = tx_data;
  end

  assign w_local   = (tx_dstx == X_AW'(X_POS)) && (tx_dsty == Y_AW'(Y_POS));
  assign w_ej_pop  = !w_ej_empty && rx_rdy;
  // A same-cycle pop frees a slot, so a full ejection FIFO can still accept.
  assign w_ej_room = !w_ej_full || w_ej_pop;
  assign w_inj_pop = !w_inj_empty && peout_rdy;

  assign tx_rdy     = w_local ? (!peout_vld && w_ej_room) : !w_inj_full;
  assign w_inj_push = tx_vld && !w_local && !w_inj_full;
  assign w_drop     = peout_vld && !w_ej_room;

  always_comb begin
    w_ej_src = EJ_NONE;
    if (peout_vld && w_ej_room)
      w_ej_src = EJ_NET;
    else if (tx_vld && w_local && !peout_vld && w_ej_room)
      w_ej_src = EJ_LOOP;
  end

  assign w_ej_push = (w_ej_src != EJ_NONE);
  assign w_ej_din  = (w_ej_src == EJ_LOOP) ? w_tx_pkt : yout_pkt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_drop_cnt <= '0;
      r_ovf      <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
      if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  pkt_fifo #(.W(P_W), .DEPTH(DEPTH)) u_inj_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_inj_push),
    .i_din   (w_tx_pkt),
    .i_pop   (w_inj_pop),
    .o_dout  (pein_pkt),
    .o_full  (w_inj_full),
    .o_empty (w_inj_empty)
  );

  pkt_fifo #(.W(P_W), .DEPTH(DEPTH)) u_ej_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_ej_push),
    .i_din   (w_ej_din),
    .i_pop   (w_ej_pop),
    .o_dout  (rx_pkt),
    .o_full  (w_ej_full),
    .o_empty (w_ej_empty)
  );

  assign pein_vld = !w_inj_empty;
  assign rx_vld   = !w_ej_empty;
  assign drop_cnt = r_drop_cnt;
  assign ovf      = r_ovf;

endmodule

// File: tb/tb_hoplite_pe_ni.sv
// Scoreboard bench for hoplite_pe_ni: queue-based model of both FIFOs, drops
// and loopback, directed scenarios followed by randomized traffic.
module tb_hoplite_pe_ni;
  localparam int P_W   = 32;
  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic [1:0]  tx_dstx;
  logic [1:0]  tx_dsty;
  logic [27:0] tx_data;
  logic        tx_vld;
  logic        tx_rdy;
  logic [31:0] pein_pkt;
  logic        pein_vld;
  logic        peout_rdy;
  logic [31:0] yout_pkt;
  logic        peout_vld;
  logic [31:0] rx_pkt;
  logic        rx_vld;
  logic        rx_rdy;
  logic [7:0]  drop_cnt;
  logic        ovf;

  hoplite_pe_ni #(.P_W(32), .X_AW(2), .Y_AW(2), .X_POS(0), .Y_POS(0), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tx_dstx   (tx_dstx),
    .tx_dsty   (tx_dsty),
    .tx_data   (tx_data),
    .tx_vld    (tx_vld),
    .tx_rdy    (tx_rdy),
    .pein_pkt  (pein_pkt),
    .pein_vld  (pein_vld),
    .peout_rdy (peout_rdy),
    .yout_pkt  (yout_pkt),
    .peout_vld (peout_vld),
    .rx_pkt    (rx_pkt),
    .rx_vld    (rx_vld),
    .rx_rdy    (rx_rdy),
    .drop_cnt  (drop_cnt),
    .ovf       (ovf)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [P_W-1:0] inj_q[$];
  logic [P_W-1:0] exp_q[$];
  int  m_drop;
  bit  m_ovf;
  bit  chk_en;
  bit  exp_tx_rdy;
  int  n_cmp;
  int  n_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Model: commits transfers at the clock edge using queue occupancy.
  always @(posedge clk) begin
    if (!rst_n) begin
      inj_q.delete();
      exp_q.delete();
      m_drop = 0;
      m_ovf  = 0;
      chk_en = 1;
    end else if (chk_en) begin
      if (peout_vld) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(yout_pkt);
        else begin
          m_ovf = 1;
          if (m_drop < 255) m_drop++;
        end
      end
      if (tx_vld && exp_tx_rdy) begin
        if (tx_dstx == 2'd0 && tx_dsty == 2'd0) exp_q.push_back({tx_data, tx_dsty, tx_dstx});
        else inj_q.push_back({tx_data, tx_dsty, tx_dstx});
      end
    end
  end

  // Monitor: compares DUT outputs mid-cycle and retires handshaken heads.
  always @(negedge clk) begin
    if (chk_en) begin
      bit e_pv, e_rv, room, loc;
      e_pv = (inj_q.size() != 0);
      e_rv = (exp_q.size() != 0);
      check("pein_vld", {31'd0, pein_vld}, {31'd0, e_pv});
      if (e_pv) check("pein_pkt", pein_pkt, inj_q[0]);
      check("rx_vld", {31'd0, rx_vld}, {31'd0, e_rv});
      if (e_rv) check("rx_pkt", rx_pkt, exp_q[0]);
      room = (exp_q.size() < DEPTH) || (e_rv && rx_rdy);
      loc  = (tx_dstx == 2'd0) && (tx_dsty == 2'd0);
      exp_tx_rdy = loc ? (!peout_vld && room) : (inj_q.size() < DEPTH);
      check("tx_rdy", {31'd0, tx_rdy}, {31'd0, exp_tx_rdy});
      check("drop_cnt", {24'd0, drop_cnt}, m_drop);
      check("ovf", {31'd0, ovf}, {31'd0, m_ovf});
      if (e_pv && peout_rdy) void'(inj_q.pop_front());
      if (e_rv && rx_rdy) void'(exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    tx_vld    = 1'b0;
    peout_vld = 1'b0;
    peout_rdy = 1'b1;
    rx_rdy    = 1'b1;
  endtask

  task automatic send_tx(input logic [1:0] x, input logic [1:0] y, input logic [27:0] d);
    tx_dstx = x;
    tx_dsty = y;
    tx_data = d;
    tx_vld  = 1'b1;
  endtask

  initial begin
    n_cmp = 0; n_err = 0; chk_en = 0; exp_tx_rdy = 0;
    m_drop = 0; m_ovf = 0;
    tx_dstx = 2'd1; tx_dsty = 2'd0; tx_data = '0; yout_pkt = '0;
    idle();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Stalled injection: head held stable until the switch takes it.
    peout_rdy = 1'b0;
    send_tx(2'd2, 2'd1, 28'h5A5A000);
    tick();
    tx_vld = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) peout_rdy = 1'b1;
      check("pein_hold_pkt", pein_pkt, 32'h5A5A0006);
      check("pein_hold_vld", {31'd0, pein_vld}, 32'd1);
      tick();
    end
    check("pein_after_pop", {31'd0, pein_vld}, 32'd0);

    // Injection FIFO fills; fifth beat refused.
    peout_rdy = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      send_tx(2'd1, 2'd0, 28'(i));
      tick();
    end
    tx_vld = 1'b0;
    peout_rdy = 1'b1;
    repeat (6) tick();

    // Ejection overflow: six arrivals, four kept.
    rx_rdy = 1'b0;
    for (int i = 0; i < 6; i++) begin
      peout_vld = 1'b1;
      yout_pkt  = $urandom;
      tick();
    end
    peout_vld = 1'b0;
    check("drop_after_flood", {24'd0, drop_cnt}, 32'd2);
    check("ovf_after_flood", {31'd0, ovf}, 32'd1);
    rx_rdy = 1'b1;
    repeat (6) tick();

    // Full FIFO with simultaneous pop and push: no drop.
    rx_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      peout_vld = 1'b1;
      yout_pkt  = $urandom;
      tick();
    end
    rx_rdy = 1'b1;
    yout_pkt = $urandom;
    tick();
    peout_vld = 1'b0;
    rx_rdy = 1'b0;
    check("drop_simul_popush", {24'd0, drop_cnt}, 32'd2);
    rx_rdy = 1'b1;
    repeat (6) tick();

    // Loopback yields to network ejection.
    rx_rdy = 1'b0;
    peout_vld = 1'b1;
    yout_pkt = 32'hC0DE0000;
    send_tx(2'd0, 2'd0, 28'hABC);
    tick();
    peout_vld = 1'b0;
    tick();
    tx_vld = 1'b0;
    rx_rdy = 1'b1;
    repeat (4) tick();

    // Reset with traffic in both FIFOs.
    peout_rdy = 1'b0;
    rx_rdy = 1'b0;
    for (int i = 0; i < 2; i++) begin
      send_tx(2'd3, 2'd3, 28'($urandom));
      peout_vld = 1'b1;
      yout_pkt = $urandom;
      tick();
    end
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rst_pein_vld", {31'd0, pein_vld}, 32'd0);
    check("rst_rx_vld", {31'd0, rx_vld}, 32'd0);
    check("rst_drop_cnt", {24'd0, drop_cnt}, 32'd0);
    check("rst_ovf", {31'd0, ovf}, 32'd0);
    tick();

    // Randomized traffic.
    for (int c = 0; c < 600; c++) begin
      send_tx(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 28'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        tx_dstx = 2'd0;
        tx_dsty = 2'd0;
      end
      tx_vld    = 1'($urandom_range(0, 1));
      peout_vld = ($urandom_range(0, 2) == 0);
      yout_pkt  = $urandom;
      peout_rdy = 1'($urandom_range(0, 1));
      rx_rdy    = ($urandom_range(0, 3) != 0);
      tick();
    end
    idle();
    repeat (8) tick();

    // Drop counter saturation.
    rx_rdy = 1'b0;
    peout_vld = 1'b1;
    for (int i = 0; i < 270; i++) begin
      yout_pkt = $urandom;
      tick();
    end
    peout_vld = 1'b0;
    check("drop_saturated", {24'd0, drop_cnt}, 32'd255);
    rx_rdy = 1'b1;
    repeat (6) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
